// File: rtl/fxp_buf_pkg.sv
// Shared types and constants for the fixed-point result drain buffer.
//   state_t   : buffer controller states
//   SEL_*     : readout section codes carried on out_sel
//   DEPTH_DEF : default number of stored result vectors
//   W_DEF     : default result word width
package fxp_buf_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_FULL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] SEL_SUM  = 2'd0;
   localparam logic [1:0] SEL_DIFF = 2'd1;
   localparam logic [1:0] SEL_MUL  = 2'd2;

   localparam int unsigned DEPTH_DEF = 240;
   localparam int unsigned W_DEF     = 16;

endpackage

// File: rtl/fxp_result_ram.sv
// Result vector storage: DEPTH entries of {borrow, cout, mul, diff, sum}.
//   clk, rst          : clock, sync reset (read register only; storage is not reset)
//   we, waddr, w*     : synchronous write port, one full vector per write
//   re, rsel, raddr   : registered read port, section-selected word
//   rdata, rflag      : selected word and its section flag (cout/borrow/0)
module fxp_result_ram
   import fxp_buf_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned IW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [W-1:0]  wsum,
   input  logic [W-1:0]  wdiff,
   input  logic [W-1:0]  wmul,
   input  logic          wcout,
   input  logic          wborrow,
   input  logic          re,
   input  logic [1:0]    rsel,
   input  logic [IW-1:0] raddr,
   output logic [W-1:0]  rdata,
   output logic          rflag
);

   localparam int unsigned EW = 3 * W + 2;

   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] rd_entry;

   // Write port: whole vector in one beat.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= {wborrow, wcout, wmul, wdiff, wsum};
      end
   end

   assign rd_entry = mem[raddr];

   // Read register doubles as the output data stage; held while re is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
         rflag <= 1'b0;
      end else if (re) begin
         unique case (rsel)
            SEL_SUM: begin
               rdata <= rd_entry[W-1:0];
               rflag <= rd_entry[3*W];
            end
            SEL_DIFF: begin
               rdata <= rd_entry[2*W-1:W];
               rflag <= rd_entry[3*W+1];
            end
            default: begin
               rdata <= rd_entry[3*W-1:2*W];
               rflag <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fxp_result_drain.sv
// Captures result vectors from the add/sub/mul unit and reads them back as one
// ordered word stream: all sums, then all differences, then all products.
//   clk, rst                     : clock, sync active-high reset
//   in_valid/in_ready, in_*      : result vector capture handshake
//   start                        : begin readout pulse
//   out_valid/out_ready, out_*   : readout stream with section, flag, index, last
//   count                        : vectors stored
//   busy                         : readout in progress
module fxp_result_drain
   import fxp_buf_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned W     = W_DEF,
   parameter int unsigned IW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_sum,
   input  logic [W-1:0]  in_diff,
   input  logic [W-1:0]  in_mul,
   input  logic          in_cout,
   input  logic          in_borrow,
   input  logic          start,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [1:0]    out_sel,
   output logic          out_flag,
   output logic [IW-1:0] out_index,
   output logic          out_last,
   output logic [IW-1:0] count,
   output logic          busy
);

   state_t        state, state_nxt;
   logic          accept, honour, load, finish;
   logic [IW-1:0] count_acc;
   logic [IW-1:0] last_idx;
   logic [1:0]    f_sec;
   logic [IW-1:0] f_idx;

   assign in_ready = (state == ST_FILL);
   assign last_idx = count - IW'(1);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_FILL;
      else     state <= state_nxt;
   end

   // Next state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      honour    = 1'b0;
      load      = 1'b0;
      finish    = 1'b0;
      count_acc = count;
      unique case (state)
         ST_FILL: begin
            accept    = in_valid;
            count_acc = in_valid ? count + IW'(1) : count;
            // A beat accepted alongside start is part of the readout.
            if (start && (count_acc != '0)) begin
               honour    = 1'b1;
               state_nxt = ST_DRAIN;
            end else if (in_valid && (count_acc == IW'(DEPTH))) begin
               state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (start) begin
               honour    = 1'b1;
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            finish = out_valid && out_ready && out_last;
            // Refill the output stage when empty or when its word leaves.
            load   = !out_valid || (out_ready && !out_last);
            if (finish) state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   // Counters, fetch pointer and output control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count     <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_sel   <= SEL_SUM;
         out_index <= '0;
         f_sec     <= SEL_SUM;
         f_idx     <= '0;
      end else begin
         busy  <= (state_nxt == ST_DRAIN);
         count <= count_acc;
         if (honour) begin
            f_sec <= SEL_SUM;
            f_idx <= '0;
         end
         if (load) begin
            out_valid <= 1'b1;
            out_sel   <= f_sec;
            out_index <= f_idx;
            out_last  <= (f_sec == SEL_MUL) && (f_idx == last_idx);
            if (f_idx == last_idx) begin
               f_idx <= '0;
               f_sec <= f_sec + 2'd1;
            end else begin
               f_idx <= f_idx + IW'(1);
            end
         end
         if (finish) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            count     <= '0;
         end
      end
   end

   fxp_result_ram #(
      .DEPTH (DEPTH),
      .W     (W),
      .IW    (IW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (accept),
      .waddr   (count),
      .wsum    (in_sum),
      .wdiff   (in_diff),
      .wmul    (in_mul),
      .wcout   (in_cout),
      .wborrow (in_borrow),
      .re      (load),
      .rsel    (f_sec),
      .raddr   (f_idx),
      .rdata   (out_data),
      .rflag   (out_flag)
   );

endmodule

// File: tb/tb_fxp_result_drain.sv
// Directed bench for fxp_result_drain: capture, ordered readout, backpressure,
// ignored start, same-cycle start/accept and reset during readout.
module tb_fxp_result_drain;

   localparam int unsigned DEPTH = 240;
   localparam int unsigned W     = 16;
   localparam int unsigned IW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_sum, in_diff, in_mul;
   logic          in_cout, in_borrow;
   logic          start;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [1:0]    out_sel;
   logic          out_flag;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic [IW-1:0] count;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // Reference copy of what has been captured.
   logic [W-1:0] m_sum [DEPTH];
   logic [W-1:0] m_diff[DEPTH];
   logic [W-1:0] m_mul [DEPTH];
   logic         m_cout[DEPTH];
   logic         m_brw [DEPTH];
   int           m_count = 0;

   always #5 clk = ~clk;

   fxp_result_drain #(.DEPTH(DEPTH), .W(W), .IW(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_diff   (in_diff),
      .in_mul    (in_mul),
      .in_cout   (in_cout),
      .in_borrow (in_borrow),
      .start     (start),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_flag  (out_flag),
      .out_index (out_index),
      .out_last  (out_last),
      .count     (count),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {sel, flag, last, index, data} for word k of an n-entry readout.
   function automatic logic [27:0] exp_word(input int k, input int n);
      int sec, idx;
      logic [W-1:0] d;
      logic f;
      sec = k / n;
      idx = k % n;
      if (sec == 0)      begin d = m_sum[idx];  f = m_cout[idx]; end
      else if (sec == 1) begin d = m_diff[idx]; f = m_brw[idx];  end
      else               begin d = m_mul[idx];  f = 1'b0;        end
      return {2'(sec), f, (k == 3 * n - 1), 8'(idx), d};
   endfunction

   // Drive one beat for a cycle; the model stores it if the buffer is not full.
   task automatic drive_beat(input logic [W-1:0] s, input logic [W-1:0] d,
                             input logic [W-1:0] m, input logic c, input logic b,
                             input logic st);
      in_valid = 1'b1; in_sum = s; in_diff = d; in_mul = m;
      in_cout = c; in_borrow = b; start = st;
      if (m_count < int'(DEPTH)) begin
         m_sum[m_count] = s; m_diff[m_count] = d; m_mul[m_count] = m;
         m_cout[m_count] = c; m_brw[m_count] = b;
         m_count++;
      end
      @(negedge clk);
      in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Follow a readout whose start was honoured at the last edge.
   task automatic drain(input int n, input bit rnd, input int abort_at);
      int k, cyc;
      k = 0; cyc = 0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("valid_latency", 32'(out_valid), 32'd0);
      while (k < 3 * n && k != abort_at && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check("first_valid", 32'(out_valid), 32'd1);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            check("word", 32'({out_sel, out_flag, out_last, out_index, out_data}),
                  32'(exp_word(k, n)));
            if (out_ready) k++;
         end
      end
      if (cyc >= 20000) check("drain_timeout", 32'(k), 32'(3 * n));
      if (k == 3 * n) begin
         @(negedge clk);
         out_ready = 1'b0;
         m_count = 0;
         check("end_valid", 32'(out_valid), 32'd0);
         check("end_count", 32'(count), 32'd0);
         check("end_in_ready", 32'(in_ready), 32'd1);
         check("end_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; start = 1'b0; out_ready = 1'b0;
      in_sum = '0; in_diff = '0; in_mul = '0; in_cout = 1'b0; in_borrow = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state.
      check("rst_count", 32'(count), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_outs", 32'({out_data, out_index, out_sel, out_flag}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Ignored start with empty buffer.
      pulse_start();
      check("ign_busy", 32'(busy), 32'd0);
      check("ign_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("ign_valid2", 32'(out_valid), 32'd0);

      // Partial capture of three hand-picked vectors.
      drive_beat(16'h1234, 16'hEDCC, 16'h8000, 1'b1, 1'b0, 1'b0);
      drive_beat(16'h7FFF, 16'h8001, 16'hFFFE, 1'b0, 1'b1, 1'b0);
      drive_beat(16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0);
      check("part_count", 32'(count), 32'd3);
      pulse_start();
      drain(3, 1'b0, -1);

      // Backpressure with random out_ready.
      for (int i = 0; i < 6; i++)
         drive_beat(16'(16'hA000 + i * 16'h0111), 16'(16'h5000 - i), 16'(i * 16'h0403),
                    1'(i), 1'(i >> 1), 1'b0);
      pulse_start();
      drain(6, 1'b1, -1);

      // Start in the same cycle as the fifth accepted beat.
      for (int i = 0; i < 4; i++)
         drive_beat(16'(i + 1), 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b0, 1'b1, 1'b0);
      drive_beat(16'hBEEF, 16'hCAFE, 16'h0F0F, 1'b1, 1'b0, 1'b1);
      check("simul_count", 32'(count), 32'd5);
      drain(5, 1'b0, -1);

      // Reset in the middle of a readout.
      drive_beat(16'h0011, 16'h0022, 16'h0033, 1'b0, 1'b0, 1'b0);
      drive_beat(16'h0044, 16'h0055, 16'h0066, 1'b1, 1'b1, 1'b0);
      drive_beat(16'h0077, 16'h0088, 16'h0099, 1'b0, 1'b1, 1'b0);
      pulse_start();
      drain(3, 1'b0, 5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
      m_count = 0;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      drive_beat(16'h4321, 16'h1234, 16'h5555, 1'b1, 1'b0, 1'b0);
      drive_beat(16'hFFFF, 16'h0000, 16'hAAAA, 1'b0, 1'b1, 1'b0);
      pulse_start();
      drain(2, 1'b0, -1);

      // Full capture: sum=i, diff=-i, mul=2i, cout=i[0].
      for (int i = 0; i < int'(DEPTH); i++)
         drive_beat(16'(i), 16'(-i), 16'(2 * i), 1'(i), 1'b0, 1'b0);
      check("full_count", 32'(count), 32'd240);
      check("full_in_ready", 32'(in_ready), 32'd0);
      drive_beat(16'hDEAD, 16'hDEAD, 16'hDEAD, 1'b1, 1'b1, 1'b0);
      check("full_ignore", 32'(count), 32'd240);
      check("w240_expect", 32'(exp_word(240, 240)), 32'({2'd1, 1'b0, 1'b0, 8'd0, 16'h0000}));
      check("w719_expect", 32'(exp_word(719, 240)), 32'({2'd2, 1'b0, 1'b1, 8'd239, 16'h01DE}));
      pulse_start();
      drain(240, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
